// File: rtl/full_adder_4bit.sv
// Registered WIDTH-bit ripple-carry adder: {cout, s} <= a + b + cin, one clock of latency.
// Optional build macro FULL_ADDER_4BIT_OVF_EN adds a registered two's-complement
// overflow flag on port ovf. With the macro undefined, the port and its logic are absent.
module full_adder_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef FULL_ADDER_4BIT_OVF_EN
  input  logic             cin,
  output logic             ovf
`else
  input  logic             cin
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
`ifdef FULL_ADDER_4BIT_OVF_EN
  logic             ovf_d;
`endif

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    c      = '0;
    s_d    = '0;
    c[0]   = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      s_d[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout_d = c[WIDTH];
`ifdef FULL_ADDER_4BIT_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
`endif
  end

  // Capture the result every edge; reset clears outputs without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
`ifdef FULL_ADDER_4BIT_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      s    <= s_d;
      cout <= cout_d;
`ifdef FULL_ADDER_4BIT_OVF_EN
      ovf  <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_full_adder_4bit.sv
// Self-checking bench for full_adder_4bit: an arithmetic reference model checked every
// cycle, plus directed vectors with literal expectations. Honours FULL_ADDER_4BIT_OVF_EN.
module tb_full_adder_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] s;
  logic       cout;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
`ifdef FULL_ADDER_4BIT_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  full_adder_4bit #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .s    (s),
    .cout (cout),
    .a    (a),
    .b    (b),
`ifdef FULL_ADDER_4BIT_OVF_EN
    .cin  (cin),
    .ovf  (ovf)
`else
    .cin  (cin)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer sum, and signed range test for overflow.
  function automatic logic ovf_of(logic [3:0] x, logic [3:0] y, logic ci);
    int sx, sy, t;
    sx = $signed(x);
    sy = $signed(y);
    t  = sx + sy + int'(ci);
    return (t > 7) || (t < -8);
  endfunction

  logic [4:0] exp_sum;
  logic       exp_ovf;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_sum <= '0;
      exp_ovf <= 1'b0;
    end else begin
      exp_sum <= {1'b0, a} + {1'b0, b} + {4'b0, cin};
      exp_ovf <= ovf_of(a, b, cin);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model-vs-DUT comparison on every falling edge once running.
  always @(negedge clk) begin
    if (run) begin
      chk("model_sum", {27'b0, cout, s}, {27'b0, exp_sum});
`ifdef FULL_ADDER_4BIT_OVF_EN
      chk("model_ovf", {31'b0, ovf}, {31'b0, exp_ovf});
`endif
    end
  end

  task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                       input logic [3:0] es, input logic ec, input string name);
    @(negedge clk);
    a   = ta;
    b   = tb;
    cin = tc;
    @(posedge clk);
    #1;
    chk({name, "_s"}, {28'b0, s}, {28'b0, es});
    chk({name, "_cout"}, {31'b0, cout}, {31'b0, ec});
    chk({name, "_model"}, {27'b0, exp_sum}, {27'b0, ec, es});
  endtask

  initial begin
    rst = 1'b1;
    a   = 4'h0;
    b   = 4'h0;
    cin = 1'b0;
    #12;
    chk("reset_s", {28'b0, s}, 32'h0);
    chk("reset_cout", {31'b0, cout}, 32'h0);
`ifdef FULL_ADDER_4BIT_OVF_EN
    chk("reset_ovf", {31'b0, ovf}, 32'h0);
`endif
    rst = 1'b0;
    run = 1'b1;

    apply(4'h3, 4'h4, 1'b0, 4'h7, 1'b0, "basic");
    apply(4'h0, 4'h0, 1'b1, 4'h1, 1'b0, "carry_in");
    apply(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, "wrap");
    apply(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "max");
    apply(4'hF, 4'h0, 1'b1, 4'h0, 1'b1, "wrap_cin");

    // Async reset mid-cycle must clear outputs before the next edge.
    apply(4'hF, 4'hF, 1'b0, 4'hE, 1'b1, "pre_reset");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_s", {28'b0, s}, 32'h0);
    chk("async_rst_cout", {31'b0, cout}, 32'h0);
    @(posedge clk);
    #1;
    chk("held_rst_s", {28'b0, s}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_s", {28'b0, s}, 32'hE);
    chk("post_rst_cout", {31'b0, cout}, 32'h1);

`ifdef FULL_ADDER_4BIT_OVF_EN
    apply(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, "ovf_pos");
    chk("ovf_pos_flag", {31'b0, ovf}, 32'h1);
    apply(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, "ovf_neg");
    chk("ovf_neg_flag", {31'b0, ovf}, 32'h1);
    apply(4'h2, 4'h3, 1'b0, 4'h5, 1'b0, "no_ovf");
    chk("no_ovf_flag", {31'b0, ovf}, 32'h0);
`endif

    // Exhaustive sweep, one operand set per cycle; the compare process checks each.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      {a, b, cin} = 9'(i);
    end
    @(negedge clk);
    @(negedge clk);
    run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
